deinter_ctrl: RTL and testbench
===============================

# deinter_ctrl

Symbol-level sequencer in front of the OFDM deinterleaver. Latches per-packet rate and symbol count, admits exactly one OFDM symbol of demodulated carriers at a time, and holds off the demodulator while the deinterleaver drains its output burst. Flags symbol completion, packet completion and stalled drains to the packet-level controller.

## Interface
Parameters:
- DRAIN_TIMEOUT, 255: max cycles in DRAIN before abort.
- INIT_CYCLES, 2: cycles `deint_reset` is held at packet start.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; low freezes all state.
- pkt_start  in  1  one-cycle pulse; latches `rate` and `num_sym`.
- rate  in  8  rate code; bit 7 = HT.
- num_sym  in  16  data symbols in packet.
- demod_bits  in  6  hard bits of one carrier.
- demod_soft  in  18  soft bits of one carrier.
- demod_valid  in  1  carrier available.
- demod_ready  out  1  controller accepts carrier.
- deint_in_bits  out  6  registered copy of accepted `demod_bits`.
- deint_soft_bits  out  18  registered copy of accepted `demod_soft`.
- deint_strobe  out  1  deinterleaver input strobe.
- deint_rate  out  8  latched rate.
- deint_enable  out  1  equals `enable`.
- deint_reset  out  1  active-high sync reset to deinterleaver.
- deint_out_strobe  in  1  deinterleaver output strobe.
- sym_done  out  1  one-cycle pulse per drained symbol.
- pkt_done  out  1  one-cycle pulse after last symbol.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky drain-timeout flag; cleared by `pkt_start`.
- sym_count  out  16  symbols completed in current packet.

## Operation
- Carriers per symbol N_CARR = 52 if latched rate[7], else 48.
- States: IDLE, INIT, FILL, DRAIN, DONE.
- IDLE: `demod_ready`=0. `pkt_start` → latch rate and num_sym, clear `sym_count` and `err_timeout`, go to INIT.
- INIT: `deint_reset`=1 for INIT_CYCLES cycles, then:
  - go to DONE if latched num_sym == 0;
  - otherwise go to FILL with carrier_cnt = 0.
- FILL: `demod_ready`=1. A transfer is `demod_valid & demod_ready`. Each transfer increments the 6-bit carrier_cnt. The transfer with carrier_cnt == N_CARR-1 moves to DRAIN and drops `demod_ready` combinationally in DRAIN.
- DRAIN: `demod_ready`=0. Tracks `seen_out` (set on any `deint_out_strobe`) and `idle_cnt` (cycles since last strobe, cleared on strobe).
  - Drain completes when `seen_out` & `idle_cnt` == 2. Then pulse `sym_done` and increment `sym_count`.
  - If the new count == num_sym, go to DONE; else go to FILL and clear carrier_cnt, seen_out and idle_cnt.
- Timeout: drain_cnt counts cycles in DRAIN. Reaching DRAIN_TIMEOUT without completion sets `err_timeout` and returns to IDLE. `pkt_done` is not pulsed on timeout.
- DONE: pulse `pkt_done` one cycle, go to IDLE.
- `pkt_start` in any non-IDLE state aborts the current packet. It relatches inputs and re-enters INIT; partial symbol is discarded. `sym_done` and `pkt_done` are not pulsed on abort.
- `enable`=0: state, counters and outputs hold. `deint_strobe` and the pulse outputs are forced 0 during that cycle. `demod_ready`=0.
- `sym_count` saturates at 0xFFFF.

## Timing
- Reset values: all outputs 0, except `deint_reset`=1 while `reset_n` is low. State IDLE.
- Input path latency: 1 cycle. A transfer in cycle t gives `deint_strobe`=1 in t+1, with registered bits.
- `demod_ready` is a function of state only; there is no combinational path from `demod_valid`.
- `pkt_start` in cycle t → `busy`=1 and `deint_reset`=1 from t+1.
- Drain completion: `sym_done` is asserted 3 cycles after the last `deint_out_strobe` (two idle cycles, then pulse). The next FILL begins in the same cycle as `sym_done`.
- `pkt_done` is asserted one cycle after the final `sym_done`.
- A `deint_out_strobe` in the same cycle `idle_cnt` would hit 2 takes priority and restarts idle counting.
- Timeout and completion in the same cycle: completion wins.

## Structure
- Shared package `deinter_pkg`:
  - state encoding (3-bit enum);
  - constants N_CARR_LEGACY=48 and N_CARR_HT=52;
  - function `n_carr(rate)`.
- No sub-module needed. Optionally factor the DRAIN idle/timeout counter as `drain_watch`.

## Test plan
- Legacy rate 0x0B, num_sym=2, valid held high:
  - exactly 48 strobes are accepted, then `demod_ready`=0;
  - model emits 24 out strobes then idles → `sym_done` 3 cycles after the last strobe;
  - second symbol the same → `pkt_done` one cycle after the 2nd `sym_done`, `sym_count`=2.
- HT rate 0x80, num_sym=1 → 52 transfers per symbol, `deint_rate`=0x80.
- num_sym=0 → `pkt_done` right after INIT, no `demod_ready`.
- Model never strobes in DRAIN → `err_timeout`=1 after 255 cycles, state IDLE, no `pkt_done`.
- `pkt_start` after 20 carriers → `deint_reset` is reasserted, carrier_cnt restarts, 48 more transfers are needed.
- Random `demod_valid` and `enable` gaps → forwarded data matches accepted data in order, one cycle late, with no strobes while `enable`=0.

Source files
------------

// File: rtl/deinter_pkg.sv
// Shared types and constants for the deinterleaver front-end sequencer.
package deinter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [5:0] N_CARR_LEGACY = 6'd48;
  localparam logic [5:0] N_CARR_HT     = 6'd52;

  // Rate codes with bit 7 set are HT and carry 52 data carriers per symbol.
  function automatic logic [5:0] n_carr(input logic [7:0] rate);
    return (rate >= 8'h80) ? N_CARR_HT : N_CARR_LEGACY;
  endfunction

endpackage

// File: rtl/deinter_ctrl_drain_watch.sv
// Watches the deinterleaver output burst while draining: completion after two
// quiet cycles following the last output strobe, or abort after a cycle budget.
module drain_watch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en_i,
  input  logic active_i,
  input  logic strobe_i,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic [1:0]    idle_cnt_q, idle_cnt_d;
  logic          seen_q, seen_d;

  // Completion is decided in the cycle idle_cnt would reach 2, so a strobe in
  // that same cycle restarts the count instead of finishing the symbol.
  always_comb begin
    done_o    = active_i & en_i & seen_q & ~strobe_i & (idle_cnt_q == 2'd1);
    timeout_o = active_i & en_i & ~done_o & (drain_cnt_q == CW'(TIMEOUT - 1));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    drain_cnt_d = drain_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    seen_d      = seen_q;
    if (!active_i) begin
      drain_cnt_d = '0;
      idle_cnt_d  = 2'd0;
      seen_d      = 1'b0;
    end else if (en_i) begin
      seen_d      = seen_q | strobe_i;
      idle_cnt_d  = strobe_i ? 2'd0 : ((idle_cnt_q == 2'd2) ? 2'd2 : idle_cnt_q + 2'd1);
      drain_cnt_d = drain_cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt_q <= '0;
      idle_cnt_q  <= 2'd0;
      seen_q      <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      seen_q      <= seen_d;
    end
  end

endmodule

// File: rtl/deinter_ctrl.sv
// Symbol-level sequencer in front of the OFDM deinterleaver: admits one symbol
// of carriers at a time and holds off the demodulator while the burst drains.
module deinter_ctrl
  import deinter_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned INIT_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pkt_start,
  input  logic [7:0]  rate,
  input  logic [15:0] num_sym,
  input  logic [5:0]  demod_bits,
  input  logic [17:0] demod_soft,
  input  logic        demod_valid,
  output logic        demod_ready,
  output logic [5:0]  deint_in_bits,
  output logic [17:0] deint_soft_bits,
  output logic        deint_strobe,
  output logic [7:0]  deint_rate,
  output logic        deint_enable,
  output logic        deint_reset,
  input  logic        deint_out_strobe,
  output logic        sym_done,
  output logic        pkt_done,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] sym_count
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [7:0]     rate_q, rate_d;
  logic [15:0]    num_sym_q, num_sym_d;
  logic [15:0]    sym_count_q, sym_count_d, sym_count_inc;
  logic [5:0]     carrier_cnt_q, carrier_cnt_d;
  logic [IW-1:0]  init_cnt_q, init_cnt_d;
  logic           err_q, err_d;
  logic           strobe_q, strobe_d;
  logic           sym_done_q, sym_done_d;
  logic           pkt_done_q, pkt_done_d;
  logic [5:0]     bits_q, bits_d;
  logic [17:0]    soft_q, soft_d;
  logic           xfer, last_carrier, init_last, drain_done, drain_timeout;

  assign xfer          = demod_valid & demod_ready;
  assign last_carrier  = carrier_cnt_q == (n_carr(rate_q) - 6'd1);
  assign init_last     = init_cnt_q == IW'(INIT_CYCLES - 1);
  assign sym_count_inc = (sym_count_q == 16'hFFFF) ? sym_count_q : sym_count_q + 16'd1;

  drain_watch #(.TIMEOUT(DRAIN_TIMEOUT)) u_drain_watch (
    .clock     (clock),
    .reset_n   (reset_n),
    .en_i      (enable),
    .active_i  (state_q == ST_DRAIN),
    .strobe_i  (deint_out_strobe),
    .done_o    (drain_done),
    .timeout_o (drain_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // pkt_start outranks everything, so an in-flight packet is simply restarted.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      if (pkt_start) begin
        state_d = ST_INIT;
      end else begin
        unique case (state_q)
          ST_INIT:  if (init_last) state_d = (num_sym_q == 16'd0) ? ST_DONE : ST_FILL;
          ST_FILL:  if (xfer && last_carrier) state_d = ST_DRAIN;
          ST_DRAIN: begin
            if (drain_done)         state_d = (sym_count_inc == num_sym_q) ? ST_DONE : ST_FILL;
            else if (drain_timeout) state_d = ST_IDLE;
          end
          ST_DONE:  state_d = ST_IDLE;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Pulses held in a frozen cycle are delivered on the next enabled cycle.
  always_comb begin
    demod_ready     = enable & (state_q == ST_FILL);
    deint_reset     = ~reset_n | (state_q == ST_INIT);
    busy            = state_q != ST_IDLE;
    deint_strobe    = enable & strobe_q;
    sym_done        = enable & sym_done_q;
    pkt_done        = enable & pkt_done_q;
    deint_in_bits   = bits_q;
    deint_soft_bits = soft_q;
    deint_rate      = rate_q;
    deint_enable    = enable;
    err_timeout     = err_q;
    sym_count       = sym_count_q;
  end

  always_comb begin
    rate_d        = rate_q;
    num_sym_d     = num_sym_q;
    sym_count_d   = sym_count_q;
    carrier_cnt_d = carrier_cnt_q;
    init_cnt_d    = init_cnt_q;
    err_d         = err_q;
    strobe_d      = strobe_q;
    sym_done_d    = sym_done_q;
    pkt_done_d    = pkt_done_q;
    bits_d        = bits_q;
    soft_d        = soft_q;
    if (enable) begin
      strobe_d   = xfer;
      sym_done_d = 1'b0;
      pkt_done_d = 1'b0;
      if (xfer) begin
        bits_d = demod_bits;
        soft_d = demod_soft;
      end
      if (pkt_start) begin
        rate_d        = rate;
        num_sym_d     = num_sym;
        sym_count_d   = 16'd0;
        err_d         = 1'b0;
        init_cnt_d    = '0;
        carrier_cnt_d = 6'd0;
      end else begin
        unique case (state_q)
          ST_INIT: begin
            init_cnt_d    = init_cnt_q + IW'(1);
            carrier_cnt_d = 6'd0;
          end
          ST_FILL: if (xfer) carrier_cnt_d = carrier_cnt_q + 6'd1;
          ST_DRAIN: begin
            if (drain_done) begin
              sym_count_d   = sym_count_inc;
              sym_done_d    = 1'b1;
              carrier_cnt_d = 6'd0;
            end else if (drain_timeout) begin
              err_d = 1'b1;
            end
          end
          ST_DONE: pkt_done_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rate_q        <= 8'd0;
      num_sym_q     <= 16'd0;
      sym_count_q   <= 16'd0;
      carrier_cnt_q <= 6'd0;
      init_cnt_q    <= '0;
      err_q         <= 1'b0;
      strobe_q      <= 1'b0;
      sym_done_q    <= 1'b0;
      pkt_done_q    <= 1'b0;
      // NOTE: the forwarded data registers are reset as well, because they
      // drive output ports that must read zero straight out of reset.
      bits_q        <= 6'd0;
      soft_q        <= 18'd0;
    end else begin
      rate_q        <= rate_d;
      num_sym_q     <= num_sym_d;
      sym_count_q   <= sym_count_d;
      carrier_cnt_q <= carrier_cnt_d;
      init_cnt_q    <= init_cnt_d;
      err_q         <= err_d;
      strobe_q      <= strobe_d;
      sym_done_q    <= sym_done_d;
      pkt_done_q    <= pkt_done_d;
      bits_q        <= bits_d;
      soft_q        <= soft_d;
    end
  end

endmodule

// File: tb/tb_deinter_ctrl.sv
// Directed bench for deinter_ctrl: packet sequencing, drain timing, timeout,
// abort and enable gating, with a small forwarding model for the input path.
module tb_deinter_ctrl;

  localparam int FILL_BUDGET = 2000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pkt_start;
  logic [7:0]  rate;
  logic [15:0] num_sym;
  logic [5:0]  demod_bits;
  logic [17:0] demod_soft;
  logic        demod_valid;
  logic        demod_ready;
  logic [5:0]  deint_in_bits;
  logic [17:0] deint_soft_bits;
  logic        deint_strobe;
  logic [7:0]  deint_rate;
  logic        deint_enable;
  logic        deint_reset;
  logic        deint_out_strobe;
  logic        sym_done;
  logic        pkt_done;
  logic        busy;
  logic        err_timeout;
  logic [15:0] sym_count;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          xfer_cnt = 0;
  int          n_sym = 0;
  int          n_pkt = 0;
  bit          pend = 1'b0;
  logic [23:0] exp_q[$];

  deinter_ctrl #(.DRAIN_TIMEOUT(255), .INIT_CYCLES(2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .pkt_start        (pkt_start),
    .rate             (rate),
    .num_sym          (num_sym),
    .demod_bits       (demod_bits),
    .demod_soft       (demod_soft),
    .demod_valid      (demod_valid),
    .demod_ready      (demod_ready),
    .deint_in_bits    (deint_in_bits),
    .deint_soft_bits  (deint_soft_bits),
    .deint_strobe     (deint_strobe),
    .deint_rate       (deint_rate),
    .deint_enable     (deint_enable),
    .deint_reset      (deint_reset),
    .deint_out_strobe (deint_out_strobe),
    .sym_done         (sym_done),
    .pkt_done         (pkt_done),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .sym_count        (sym_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample point; also runs the forwarding model for every cycle.
  task automatic half();
    bit          exp_str;
    bit          x;
    logic [23:0] exp_w;
    #4;
    exp_str = pend & enable;
    check("deint_strobe", 32'(deint_strobe), 32'(exp_str));
    if (exp_str) begin
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      else                  exp_w = 24'hxxxxxx;
      check("deint_data", 32'({deint_soft_bits, deint_in_bits}), 32'(exp_w));
    end
    if (!enable) check("gated_outputs", 32'({demod_ready, sym_done, pkt_done}), 32'd0);
    if (sym_done) n_sym++;
    if (pkt_done) n_pkt++;
    x = demod_valid & demod_ready;
    if (enable) pend = x;
    if (x) begin
      exp_q.push_back({demod_soft, demod_bits});
      xfer_cnt++;
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] r, input logic [15:0] ns, input bit from_idle);
    enable    = 1'b1;
    pkt_start = 1'b1;
    rate      = r;
    num_sym   = ns;
    half();
    check("busy_at_start", 32'(busy), 32'(!from_idle));
    adv();
    pkt_start = 1'b0;
    half();
    check("busy_after_start", 32'(busy), 32'd1);
    check("deint_reset_init0", 32'(deint_reset), 32'd1);
    check("ready_in_init", 32'(demod_ready), 32'd0);
    check("deint_rate", 32'(deint_rate), 32'(r));
    check("err_cleared", 32'(err_timeout), 32'd0);
    check("sym_count_cleared", 32'(sym_count), 32'd0);
    adv();
    half();
    check("deint_reset_init1", 32'(deint_reset), 32'd1);
    adv();
  endtask

  task automatic fill(input int n, input bit rnd, input bit drop);
    int budget;
    budget   = 0;
    xfer_cnt = 0;
    while (xfer_cnt < n && budget < FILL_BUDGET) begin
      enable      = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      demod_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      demod_bits  = 6'($urandom);
      demod_soft  = 18'($urandom);
      half();
      if (!rnd) check("ready_fill", 32'(demod_ready), 32'd1);
      adv();
      budget++;
    end
    if (xfer_cnt != n) check("fill_count", 32'(xfer_cnt), 32'(n));
    enable = 1'b1;
    if (drop) begin
      demod_valid = 1'b1;
      half();
      check("ready_drop", 32'(demod_ready), 32'd0);
      adv();
    end
    demod_valid = 1'b0;
  endtask

  task automatic drain(input int n_str, input bit retrig, input int exp_cnt, input bit last);
    int sym0;
    sym0 = n_sym;
    for (int i = 0; i < n_str; i++) begin
      deint_out_strobe = 1'b1;
      half();
      adv();
    end
    deint_out_strobe = 1'b0;
    if (retrig) begin
      half();
      adv();
      deint_out_strobe = 1'b1;
      half();
      adv();
      deint_out_strobe = 1'b0;
    end
    check("no_early_sym_done", 32'(n_sym), 32'(sym0));
    for (int k = 1; k <= 3; k++) begin
      half();
      check($sformatf("sym_done_t%0d", k), 32'(sym_done), 32'(k == 3));
      if (k == 3) begin
        check("sym_count", 32'(sym_count), 32'(exp_cnt));
        check("ready_after_drain", 32'(demod_ready), 32'(!last));
        check("pkt_done_with_sym", 32'(pkt_done), 32'd0);
      end
      adv();
    end
    if (last) begin
      half();
      check("pkt_done", 32'(pkt_done), 32'd1);
      check("busy_after_pkt", 32'(busy), 32'd0);
      check("sym_count_final", 32'(sym_count), 32'(exp_cnt));
      adv();
      half();
      check("pkt_done_one_cycle", 32'(pkt_done), 32'd0);
      adv();
    end
  endtask

  initial begin
    int sym0, pkt0;
    reset_n          = 1'b0;
    enable           = 1'b0;
    pkt_start        = 1'b0;
    rate             = 8'd0;
    num_sym          = 16'd0;
    demod_bits       = 6'd0;
    demod_soft       = 18'd0;
    demod_valid      = 1'b0;
    deint_out_strobe = 1'b0;
    #1;
    adv();
    adv();

    half();
    check("rst_demod_ready", 32'(demod_ready), 32'd0);
    check("rst_in_bits", 32'(deint_in_bits), 32'd0);
    check("rst_soft_bits", 32'(deint_soft_bits), 32'd0);
    check("rst_strobe", 32'(deint_strobe), 32'd0);
    check("rst_rate", 32'(deint_rate), 32'd0);
    check("rst_enable", 32'(deint_enable), 32'd0);
    check("rst_deint_reset", 32'(deint_reset), 32'd1);
    check("rst_sym_done", 32'(sym_done), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    adv();
    reset_n = 1'b1;
    enable  = 1'b1;
    half();
    check("idle_deint_reset", 32'(deint_reset), 32'd0);
    check("idle_deint_enable", 32'(deint_enable), 32'd1);
    check("idle_ready", 32'(demod_ready), 32'd0);
    adv();

    // Legacy rate, two symbols; second drain retriggers at the idle_cnt==2 point.
    start_pkt(8'h0B, 16'd2, 1'b1);
    fill(48, 1'b0, 1'b1);
    drain(24, 1'b0, 1, 1'b0);
    fill(48, 1'b0, 1'b1);
    drain(24, 1'b1, 2, 1'b1);

    // HT rate, one symbol of 52 carriers.
    start_pkt(8'h80, 16'd1, 1'b1);
    fill(52, 1'b0, 1'b1);
    half();
    check("deint_rate_ht", 32'(deint_rate), 32'h80);
    adv();
    drain(20, 1'b0, 1, 1'b1);

    // Empty packet: straight from INIT to DONE.
    start_pkt(8'h0B, 16'd0, 1'b1);
    half();
    check("empty_deint_reset", 32'(deint_reset), 32'd0);
    check("empty_ready", 32'(demod_ready), 32'd0);
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_pkt_done_early", 32'(pkt_done), 32'd0);
    adv();
    half();
    check("empty_pkt_done", 32'(pkt_done), 32'd1);
    check("empty_busy_end", 32'(busy), 32'd0);
    check("empty_sym_count", 32'(sym_count), 32'd0);
    adv();

    // Drain timeout: no output strobes ever arrive.
    start_pkt(8'h0B, 16'd1, 1'b1);
    fill(48, 1'b0, 1'b1);
    sym0 = n_sym;
    pkt0 = n_pkt;
    for (int i = 1; i <= 254; i++) begin
      half();
      if (i == 254) begin
        check("to_busy_last", 32'(busy), 32'd1);
        check("to_err_early", 32'(err_timeout), 32'd0);
      end
      adv();
    end
    half();
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    adv();
    half();
    check("to_err_sticky", 32'(err_timeout), 32'd1);
    adv();
    check("to_no_pkt_done", 32'(n_pkt), 32'(pkt0));
    check("to_no_sym_done", 32'(n_sym), 32'(sym0));

    // Abort after 20 carriers: INIT again and a full 48 carriers needed.
    start_pkt(8'h0B, 16'd1, 1'b1);
    fill(20, 1'b0, 1'b0);
    sym0 = n_sym;
    pkt0 = n_pkt;
    start_pkt(8'h0B, 16'd1, 1'b0);
    check("abort_no_sym_done", 32'(n_sym), 32'(sym0));
    check("abort_no_pkt_done", 32'(n_pkt), 32'(pkt0));
    fill(48, 1'b0, 1'b1);
    drain(10, 1'b0, 1, 1'b1);

    // Random valid and enable gaps during fill; the model checks forwarding.
    start_pkt(8'h0B, 16'd2, 1'b1);
    fill(48, 1'b1, 1'b1);
    drain(24, 1'b0, 1, 1'b0);
    fill(48, 1'b1, 1'b1);
    drain(24, 1'b0, 2, 1'b1);
    check("fwd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
